mem_port_arbiter: RTL and testbench

- Shares the single-port 16-bit data/instruction memory between two requesters: instruction fetch (IF) and data load/store (D).
- Sequences each access over a fixed memory latency and returns read data with a one-cycle valid pulse.
- Sits between the control unit / PC logic and the memory datapath; drives the memory address, write data and write enable.

---
 rtl/mem_port_arbiter_pkg.sv | 8 +
 rtl/mem_arb_select.sv | 19 +
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state/owner encodings and latency bounds for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;
  localparam int CNT_W = 4;
endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select: combinational owner pick; MEM_ARB_RR_EN selects round-robin on contention
module mem_arb_select
  import mem_port_arbiter_pkg::*;
(
  input  logic if_req_i,
  input  logic d_req_i,
  input  logic last_owner_i,
  output logic any_req_o,
  output logic owner_o
);
  assign any_req_o = if_req_i | d_req_i;
`ifdef MEM_ARB_RR_EN
  assign owner_o = (if_req_i && d_req_i) ? (last_owner_i == OWN_IF ? OWN_D : OWN_IF) : d_req_i;
`else
  logic unused_last;
  assign unused_last = last_owner_i;
  assign owner_o = d_req_i;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data, fixed-latency access sequencing.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of data-over-fetch priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam int LAT_C = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                         (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic acc_we_q, acc_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic mem_we_q, mem_we_d;
  logic if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic any_req, sel, grant, sel_we;
  mem_arb_select u_sel (
    .if_req_i    (if_req),
    .d_req_i     (d_req),
    .last_owner_i(owner_q),
    .any_req_o   (any_req),
    .owner_o     (sel)
  );
  // reset masks the grant so a request during reset is neither acknowledged nor latched
  assign grant  = (state_q == IDLE) && any_req && !reset;
  assign if_gnt = grant && (sel == OWN_IF);
  assign d_gnt  = grant && (sel == OWN_D);
  assign sel_we = (sel == OWN_D) && d_we;
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    acc_we_d    = acc_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if (grant) begin
      state_d     = ACCESS;
      owner_d     = owner_e'(sel);
      cnt_d       = CNT_W'(LAT_C);
      acc_we_d    = sel_we;
      mem_we_d    = sel_we;
      mem_addr_d  = (sel == OWN_D) ? d_addr : if_addr;
      mem_wdata_d = (sel == OWN_D) ? d_wdata : mem_wdata_q;
    end else if (state_q == ACCESS) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d     = IDLE;
        if_rvalid_d = (owner_q == OWN_IF);
        d_rvalid_d  = (owner_q == OWN_D);
        if_rdata_d  = (owner_q == OWN_IF) ? mem_rdata : if_rdata_q;
        d_rdata_d   = (owner_q == OWN_D && !acc_we_q) ? mem_rdata : d_rdata_q;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      acc_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      acc_we_q    <= acc_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q == ACCESS);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench; stimulus pushes expected completions, a negedge monitor checks them
module tb_mem_port_arbiter;
  localparam int LAT = 3;
  typedef struct {
    bit          is_d;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] data;
    int          t;
  } exp_t;
  logic clock = 1'b0, reset = 1'b1;
  logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_we, busy;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  int tests = 0, fails = 0, cyc = 0;
  exp_t q[$];
  bit gnt_log[$];
  logic [15:0] last_d = '0;
  logic [15:0] mem [logic [15:0]];
  logic [15:0] shadow [logic [15:0]];

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hA5A5 : (a ^ 16'h5A5A);
  endfunction

  // memory model: registered read, so data for an address shown in cycle k is present in k+1
  always @(posedge clock) begin
    mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : init_val(mem_addr);
    if (mem_we) mem[mem_addr] = mem_wdata;
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic logic [15:0] rd_shadow(input logic [15:0] a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (if_gnt || d_gnt) begin
      chk("gnt_excl", {31'd0, if_gnt & d_gnt}, 0);
      chk("gnt_when_busy", {31'd0, busy}, 0);
      gnt_log.push_back(d_gnt);
    end
    if (if_rvalid || d_rvalid) begin
      chk("rvalid_excl", {31'd0, if_rvalid & d_rvalid}, 0);
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_rvalid: got if=%0b d=%0b expected none", if_rvalid, d_rvalid);
      end else begin
        e = q.pop_front();
        chk("rv_port", {31'd0, d_rvalid}, {31'd0, e.is_d});
        chk("rv_time", cyc, e.t + LAT + 1);
        if (e.is_d) begin
          if (!e.we) last_d = e.data;
          chk("d_rdata", {16'd0, d_rdata}, {16'd0, last_d});
        end else chk("if_rdata", {16'd0, if_rdata}, {16'd0, e.data});
      end
    end else if (q.size() > 0 && cyc > q[0].t + LAT + 1) begin
      tests++; fails++;
      $display("FAIL rvalid_timeout: got none by cycle %0d expected at %0d", cyc, q[0].t + LAT + 1);
      void'(q.pop_front());
    end
    if (q.size() > 0 && cyc == q[0].t + 1) begin
      chk("mem_addr", {16'd0, mem_addr}, {16'd0, q[0].addr});
      chk("mem_we", {31'd0, mem_we}, {31'd0, q[0].we});
      if (q[0].we) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, q[0].wdata});
    end
    if (q.size() > 0 && cyc > q[0].t + 1 && cyc <= q[0].t + LAT) begin
      chk("mem_addr_hold", {16'd0, mem_addr}, {16'd0, q[0].addr});
      chk("mem_we_low", {31'd0, mem_we}, 0);
    end
  end

  // callers enter just after a rising edge; returns just after the edge that ends the grant cycle
  task automatic do_if(input logic [15:0] a, output int t);
    int n = 0;
    if_addr = a;
    if_req = 1'b1;
    @(negedge clock);
    while (!if_gnt && n < 60) begin n++; @(negedge clock); end
    if (!if_gnt) begin
      tests++; fails++;
      $display("FAIL if_gnt_timeout: got no grant for %0h expected grant", a);
      t = -1;
    end else begin
      t = cyc;
      q.push_back('{1'b0, 1'b0, a, 16'h0, rd_shadow(a), cyc});
    end
    @(posedge clock); #1;
    if_req = 1'b0;
  endtask

  task automatic do_d(input bit we, input logic [15:0] a, input logic [15:0] wd, input bit push, output int t);
    int n = 0;
    d_we = we; d_addr = a; d_wdata = wd;
    d_req = 1'b1;
    @(negedge clock);
    while (!d_gnt && n < 60) begin n++; @(negedge clock); end
    if (!d_gnt) begin
      tests++; fails++;
      $display("FAIL d_gnt_timeout: got no grant for %0h expected grant", a);
      t = -1;
    end else begin
      t = cyc;
      if (push) begin
        q.push_back('{1'b1, we, a, wd, we ? 16'h0 : rd_shadow(a), cyc});
        if (we) shadow[a] = wd;
      end
    end
    @(posedge clock); #1;
    d_req = 1'b0;
  endtask

  task automatic idle_wait();
    repeat (LAT + 3) @(posedge clock);
    #1;
  endtask

  initial begin
    int t1, t2, t3, t4;
    logic [3:0] pat;
    if_req = 1'b1; d_req = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_flags", {26'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_we, busy}, 0);
    chk("rst_mem", {mem_addr, mem_wdata}, 0);
    chk("rst_rdata", {if_rdata, d_rdata}, 0);
    @(posedge clock); #1;
    if_req = 1'b0; d_req = 1'b0; reset = 1'b0;
    // single fetch
    do_if(16'h0010, t1);
    idle_wait();
    // contention from idle, last owner is IF: data wins in both arbitration modes
    fork
      do_d(1'b0, 16'h0020, 16'h0, 1'b1, t1);
      do_if(16'h0030, t2);
    join
    chk("contend_d_first", {31'd0, t1 < t2}, 1);
    chk("contend_if_time", t2, t1 + LAT + 1);
    idle_wait();
    // four continuous requests under contention
    gnt_log.delete();
    fork
      begin do_d(1'b0, 16'h0100, 16'h0, 1'b1, t1); do_d(1'b0, 16'h0101, 16'h0, 1'b1, t2); end
      begin do_if(16'h0200, t3); do_if(16'h0201, t4); end
    join
    chk("contend_count", gnt_log.size(), 4);
    pat = {gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]};
`ifdef MEM_ARB_RR_EN
    chk("contend_order", {28'd0, pat}, 32'b1010);
`else
    chk("contend_order", {28'd0, pat}, 32'b1100);
`endif
    idle_wait();
    // store then load of the same address
    do_d(1'b1, 16'h00F0, 16'h1234, 1'b1, t1);
    do_d(1'b0, 16'h00F0, 16'h0, 1'b1, t2);
    chk("store_load_spacing", t2 - t1, LAT + 1);
    idle_wait();
    // data request arrives mid-access and waits for the rvalid cycle
    fork
      do_if(16'h0040, t1);
      begin repeat (2) @(posedge clock); #1; do_d(1'b0, 16'h0050, 16'h0, 1'b1, t2); end
    join
    chk("late_req_grant", t2, t1 + LAT + 1);
    idle_wait();
    // reset in the cycle after a load grant aborts it
    do_d(1'b0, 16'h0060, 16'h0, 1'b0, t1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    last_d = '0;
    @(negedge clock);
    chk("abort_flags", {26'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_we, busy}, 0);
    chk("abort_mem", {mem_addr, mem_wdata}, 0);
    chk("abort_rdata", {if_rdata, d_rdata}, 0);
    @(posedge clock); #1;
    idle_wait();
    // back-to-back fetches across the address wrap
    do_if(16'hFFFE, t1);
    do_if(16'h0000, t2);
    chk("wrap_spacing", t2 - t1, LAT + 1);
    idle_wait();
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1);
  end
endmodule
